pipe_ctrl: RTL and testbench

- Hazard and sequencing controller for the five-stage Y86 pipeline.
- Generates stall and bubble controls for the F, D, E, M and W pipeline registers, plus the set_cc enable.
- Tracks the halt/exception state machine and keeps saturating performance counters.
- Purely a control block: it consumes stage fields and drives no datapath values.

---
 rtl/pipe_ctrl.sv | 177 +++++++++++++++++
 tb/tb_pipe_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - hazard, halt and performance-count controller for the five-stage Y86 pipeline
module pipe_ctrl #(
  parameter int       CNT_W    = 32,
  parameter bit [2:0] STAT_AOK = 3'd1,
  parameter bit [2:0] STAT_HLT = 3'd2,
  parameter bit [2:0] STAT_ADR = 3'd3,
  parameter bit [2:0] STAT_INS = 3'd4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [3:0]       M_icode,
  input  logic [2:0]       m_stat,
  input  logic [3:0]       W_icode,
  input  logic [2:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             set_cc,
  output logic             halted,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] lu_cnt,
  output logic [CNT_W-1:0] mp_cnt
);

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] R_NONE   = 4'hF;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_HALTED = 2'b10
  } state_t;

  state_t state_q;
  state_t state_d;

  logic lu;
  logic mp;
  logic rt;
  logic exc_m;
  logic exc_w;
  logic retire;
  logic cnt_en;

  // Any status other than AOK stops the machine; undefined codes are
  // treated as faults so the pipe never keeps running on a garbage status.
  function automatic logic is_fault(input logic [2:0] stat);
    logic f;
    case (stat)
      STAT_AOK:                     f = 1'b0;
      STAT_HLT, STAT_ADR, STAT_INS: f = 1'b1;
      default:                      f = 1'b1;
    endcase
    return f;
  endfunction

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic en);
    logic [CNT_W-1:0] r;
    if (en && (v != CNT_MAX)) r = v + CNT_ONE;
    else                      r = v;
    return r;
  endfunction

  // Hazard detection terms from the current stage fields.
  always_comb begin
    lu     = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) &&
             (E_dstM != R_NONE) &&
             ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    mp     = (E_icode == I_JXX) && !e_Cnd;
    rt     = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    exc_m  = is_fault(m_stat);
    exc_w  = is_fault(W_stat);
    retire = !is_fault(W_stat) && (W_icode != I_NOP);
    cnt_en = !reset && (state_q != ST_HALTED);
  end

  // Halt/exception state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // Next state and pipeline register controls; reset forces flush bubbles,
  // HALTED freezes every register except the bubbled E and M stages.
  always_comb begin
    state_d  = state_q;
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = 1'b0;
    W_stall  = 1'b0;
    set_cc   = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (exc_w)      state_d = ST_HALTED;
        else if (exc_m) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (exc_w) state_d = ST_HALTED;
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_HALTED;
    endcase

    if (reset) begin
      D_bubble = 1'b1;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
    end else if (state_q == ST_HALTED) begin
      F_stall  = 1'b1;
      D_stall  = 1'b1;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
      W_stall  = 1'b1;
    end else begin
      // A load/use stall holds D, so it overrides the ret bubble there.
      F_stall  = lu || rt;
      D_stall  = lu;
      D_bubble = mp || (rt && !lu);
      E_bubble = mp || lu;
      M_bubble = exc_m || exc_w;
      W_stall  = exc_w;
      set_cc   = (E_icode == I_OPQ) && !exc_m && !exc_w;
    end
  end

  assign state  = state_q;
  assign halted = (state_q == ST_HALTED);

  // Cycle counter: the cycle that enters HALTED still counts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cycle_cnt <= '0;
    else       cycle_cnt <= sat_inc(cycle_cnt, cnt_en);
  end

  // Retired-instruction counter; bubbles and real NOPs both look like NOP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) retire_cnt <= '0;
    else       retire_cnt <= sat_inc(retire_cnt, cnt_en && retire);
  end

  // Load/use stall counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lu_cnt <= '0;
    else       lu_cnt <= sat_inc(lu_cnt, cnt_en && lu);
  end

  // Mispredicted-branch counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) mp_cnt <= '0;
    else       mp_cnt <= sat_inc(mp_cnt, cnt_en && mp);
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, W_icode;
  logic       e_Cnd;
  logic [2:0] m_stat, W_stat;

  logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall;
  logic        set_cc, halted;
  logic [1:0]  state;
  logic [31:0] cycle_cnt, retire_cnt, lu_cnt, mp_cnt;

  logic        F_stall4, D_stall4, D_bubble4, E_bubble4, M_bubble4, W_stall4;
  logic        set_cc4, halted4;
  logic [1:0]  state4;
  logic [3:0]  cycle_cnt4, retire_cnt4, lu_cnt4, mp_cnt4;

  logic [5:0]  ctrl;
  assign ctrl = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall};

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk(clk), .reset(reset), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode),
    .m_stat(m_stat), .W_icode(W_icode), .W_stat(W_stat),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
    .M_bubble(M_bubble), .W_stall(W_stall), .set_cc(set_cc), .halted(halted),
    .state(state), .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt),
    .lu_cnt(lu_cnt), .mp_cnt(mp_cnt)
  );

  pipe_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode),
    .m_stat(m_stat), .W_icode(W_icode), .W_stat(W_stat),
    .F_stall(F_stall4), .D_stall(D_stall4), .D_bubble(D_bubble4), .E_bubble(E_bubble4),
    .M_bubble(M_bubble4), .W_stall(W_stall4), .set_cc(set_cc4), .halted(halted4),
    .state(state4), .cycle_cnt(cycle_cnt4), .retire_cnt(retire_cnt4),
    .lu_cnt(lu_cnt4), .mp_cnt(mp_cnt4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic idle();
    D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1; W_icode = 4'h1;
    d_srcA = 4'hF; d_srcB = 4'hF; E_dstM = 4'hF; e_Cnd = 1'b0;
    m_stat = 3'd1; W_stat = 3'd1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    #3;
    check("rst_state", {30'd0, state}, 32'd0);
    check("rst_ctrl", {26'd0, ctrl}, 32'b001110);
    check("rst_cycle", cycle_cnt, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);

    reset = 1'b0;
    #1;
    check("run_idle_ctrl", {26'd0, ctrl}, 32'd0);
    tick(); check("cycle_1", cycle_cnt, 32'd1);
    tick(); check("cycle_2", cycle_cnt, 32'd2);
    tick(); check("cycle_3", cycle_cnt, 32'd3);

    // load/use via srcA
    E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
    #1;
    check("lu_ctrl", {26'd0, ctrl}, 32'b110100);
    check("lu_cnt_before", lu_cnt, 32'd0);
    tick();
    check("lu_cnt_after", lu_cnt, 32'd1);
    // popq hazard via srcB
    idle(); E_icode = 4'hB; E_dstM = 4'h4; d_srcB = 4'h4;
    #1;
    check("lu_popq_srcB", {26'd0, ctrl}, 32'b110100);
    // dstM of none never matches an unused source
    idle(); E_icode = 4'h5;
    #1;
    check("lu_none_reg", {26'd0, ctrl}, 32'd0);

    // mispredict
    idle(); E_icode = 4'h7; e_Cnd = 1'b0;
    #1;
    check("mp_ctrl", {26'd0, ctrl}, 32'b001100);
    tick();
    check("mp_cnt", mp_cnt, 32'd1);
    e_Cnd = 1'b1;
    #1;
    check("jxx_taken_ctrl", {26'd0, ctrl}, 32'd0);

    // ret with load/use: stall wins
    idle(); D_icode = 4'h9; E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
    #1;
    check("ret_lu_ctrl", {26'd0, ctrl}, 32'b110100);
    tick();
    idle(); M_icode = 4'h9;
    #1;
    check("ret_m_ctrl", {26'd0, ctrl}, 32'b101000);
    idle(); D_icode = 4'h9; E_icode = 4'h7; e_Cnd = 1'b0;
    #1;
    check("ret_mp_ctrl", {26'd0, ctrl}, 32'b101100);

    // set_cc and retirement
    idle(); E_icode = 4'h6; W_icode = 4'h6;
    #1;
    check("set_cc_opq", {31'd0, set_cc}, 32'd1);
    tick();
    check("retire_1", retire_cnt, 32'd1);
    check("cycle_7", cycle_cnt, 32'd7);

    // exception drain
    idle(); E_icode = 4'h6; m_stat = 3'd3;
    #1;
    check("exc_m_ctrl", {26'd0, ctrl}, 32'b000010);
    check("exc_m_set_cc", {31'd0, set_cc}, 32'd0);
    tick();
    check("state_drain", {30'd0, state}, 32'd1);
    W_stat = 3'd3; W_icode = 4'h6;
    #1;
    check("exc_w_ctrl", {26'd0, ctrl}, 32'b000011);
    tick();
    check("state_halted", {30'd0, state}, 32'd2);
    check("halted", {31'd0, halted}, 32'd1);
    check("halt_ctrl", {26'd0, ctrl}, 32'b110111);
    idle(); E_icode = 4'h6; E_dstM = 4'h3; d_srcA = 4'h3; E_icode = 4'h5;
    #1;
    check("halt_ctrl_forced", {26'd0, ctrl}, 32'b110111);
    E_icode = 4'h6;
    #1;
    check("halt_set_cc", {31'd0, set_cc}, 32'd0);
    for (int i = 0; i < 5; i++) tick();
    check("cycle_frozen", cycle_cnt, 32'd9);
    check("retire_frozen", retire_cnt, 32'd1);
    check("lu_frozen", lu_cnt, 32'd2);

    // async reset between edges while halted
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid_state", {30'd0, state}, 32'd0);
    check("rst_mid_cycle", cycle_cnt, 32'd0);
    check("rst_mid_lu", lu_cnt, 32'd0);
    check("rst_mid_ctrl", {26'd0, ctrl}, 32'b001110);
    check("rst_mid_halted", {31'd0, halted}, 32'd0);
    #1;
    reset = 1'b0;
    idle();
    #1;
    check("post_rst_ctrl", {26'd0, ctrl}, 32'd0);
    tick(); check("post_rst_cycle_1", cycle_cnt, 32'd1);
    tick(); check("post_rst_cycle_2", cycle_cnt, 32'd2);
    tick(); check("post_rst_cycle_3", cycle_cnt, 32'd3);

    // saturation on the 4-bit instance
    #2;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    idle(); E_icode = 4'h6; W_icode = 4'h6;
    for (int i = 0; i < 20; i++) tick();
    check("sat4_cycle", {28'd0, cycle_cnt4}, 32'd15);
    check("sat4_retire", {28'd0, retire_cnt4}, 32'd15);
    check("wide_cycle", cycle_cnt, 32'd20);
    check("wide_retire", retire_cnt, 32'd20);
    tick(); tick();
    check("sat4_cycle_held", {28'd0, cycle_cnt4}, 32'd15);
    check("sat4_retire_held", {28'd0, retire_cnt4}, 32'd15);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
